// File: rtl/popcount_decoder_seq_if.sv
// Request/handshake bundle for the popcount pattern sequencer.
// The slave side is the sequencer; the master side issues requests and accepts words.
interface popcount_decoder_seq_if;
  logic [2:0] Count;
  logic       Start;
  logic       Ready;
  logic       Busy;
  logic [3:0] Word;
  logic       Valid;
  logic       Last;
  logic       Error;

  modport slave (
    input  Count, Start, Ready,
    output Busy, Word, Valid, Last, Error
  );

  modport master (
    output Count, Start, Ready,
    input  Busy, Word, Valid, Last, Error
  );
endinterface

// File: rtl/popcount_decoder_seq.sv
// Emits, in ascending order, every 4-bit pattern whose population count equals
// the requested Count, with a Valid/Ready handshake and a Last marker.
module popcount_decoder_seq (
  input  logic                   Clock,
  input  logic                   nReset,
  popcount_decoder_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Highest pattern with n ones: ones packed at the MSB end.
  function automatic logic [3:0] top_pattern(input logic [2:0] n);
    logic [3:0] p;
    case (n)
      3'd0:    p = 4'b0000;
      3'd1:    p = 4'b1000;
      3'd2:    p = 4'b1100;
      3'd3:    p = 4'b1110;
      default: p = 4'b1111;
    endcase
    return p;
  endfunction

  logic [1:0] r_state;
  logic [3:0] r_c;
  logic [2:0] r_n;
  logic [3:0] r_word;
  logic       r_valid;
  logic       r_last;
  logic       r_err;

  logic w_stall;
  logic w_match;
  logic w_top;

  assign w_stall = r_valid && !bus.Ready;
  assign w_match = (popcnt4(r_c) == r_n);
  assign w_top   = (r_c == top_pattern(r_n));

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_c     <= 4'd0;
      r_n     <= 3'd0;
      r_word  <= 4'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            if (bus.Count > 3'd4) begin
              r_err <= 1'b1;
            end else begin
              r_n     <= bus.Count;
              r_c     <= 4'd0;
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          // c never wraps inside a request: the top pattern always ends the scan.
          if (!w_stall) begin
            r_c <= r_c + 4'd1;
            if (w_match) begin
              r_word  <= r_c;
              r_valid <= 1'b1;
              r_last  <= w_top;
              if (w_top) r_state <= S_DRAIN;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (r_valid && bus.Ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy  = (r_state != S_IDLE);
  assign bus.Word  = r_word;
  assign bus.Valid = r_valid;
  assign bus.Last  = r_last;
  assign bus.Error = r_err;

endmodule

// File: tb/tb_popcount_decoder_seq.sv
// Randomized bench for popcount_decoder_seq against a pattern-list reference model.
module tb_popcount_decoder_seq;

  logic Clock = 1'b0;
  logic nReset;

  popcount_decoder_seq_if bus();

  popcount_decoder_seq dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // mode 0: Ready always 1; mode 1: random Ready; mode 2: stall 3 cycles on 0100.
  task automatic run_req(input int n, input int mode, input bit poke);
    logic [3:0] exp_q[$];
    logic [3:0] pw;
    logic       pv, pl, r;
    int idx, e, stalls, poke_at;
    bit done;
    for (int v = 0; v < 16; v++)
      if ($countones(v[3:0]) == n) exp_q.push_back(v[3:0]);
    bus.Start = 1'b1;
    bus.Count = n[2:0];
    bus.Ready = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("busy_after_start", {31'd0, bus.Busy}, 32'd1);
    idx = 0; e = 0; stalls = 0; done = 0;
    poke_at = $urandom_range(1, 8);
    for (int it = 0; it < 120 && !done; it++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = !(bus.Valid && bus.Word == 4'b0100 && stalls < 3);
      endcase
      if (mode == 2 && !r) stalls++;
      bus.Ready = r;
      if (poke && it == poke_at) begin
        bus.Start = 1'b1;
        bus.Count = 3'd4;
      end else begin
        bus.Start = 1'b0;
      end
      pv = bus.Valid; pw = bus.Word; pl = bus.Last;
      step();
      e++;
      if (pv && r) begin
        chk("word", {28'd0, pw}, {28'd0, exp_q[idx]});
        chk("last", {31'd0, pl}, {31'd0, idx == exp_q.size() - 1});
        idx++;
        if (idx == exp_q.size()) begin
          chk("busy_end", {31'd0, bus.Busy}, 32'd0);
          chk("valid_end", {31'd0, bus.Valid}, 32'd0);
          done = 1;
        end
      end else if (pv) begin
        chk("hold_word", {28'd0, bus.Word}, {28'd0, pw});
        chk("hold_valid", {31'd0, bus.Valid}, 32'd1);
        chk("hold_last", {31'd0, bus.Last}, {31'd0, pl});
      end
      if (!done) begin
        chk("busy_mid", {31'd0, bus.Busy}, 32'd1);
        if (mode == 0 && bus.Valid) chk("latency", e, 1 + {28'd0, bus.Word});
      end
    end
    bus.Start = 1'b0;
    bus.Ready = 1'b1;
    if (!done) chk("timeout_words", idx, exp_q.size());
    if (mode == 2) chk("stall_cycles", stalls, 3);
  endtask

  task automatic err_req(input int cnt);
    bus.Start = 1'b1;
    bus.Count = cnt[2:0];
    step();
    bus.Start = 1'b0;
    chk("err_pulse", {31'd0, bus.Error}, 32'd1);
    chk("err_busy", {31'd0, bus.Busy}, 32'd0);
    chk("err_valid", {31'd0, bus.Valid}, 32'd0);
    step();
    chk("err_clear", {31'd0, bus.Error}, 32'd0);
    chk("err_valid2", {31'd0, bus.Valid}, 32'd0);
    chk("err_busy2", {31'd0, bus.Busy}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, bus.Busy},  32'd0);
    chk({tag, "_word"},  {28'd0, bus.Word},  32'd0);
    chk({tag, "_valid"}, {31'd0, bus.Valid}, 32'd0);
    chk({tag, "_last"},  {31'd0, bus.Last},  32'd0);
    chk({tag, "_error"}, {31'd0, bus.Error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    nReset = 1'b0;
    bus.Start = 1'b0;
    bus.Count = 3'd0;
    bus.Ready = 1'b0;
    step();
    step();
    chk_zero("reset");
    nReset = 1'b1;
    step();

    run_req(2, 0, 0);
    run_req(0, 0, 0);
    run_req(4, 0, 0);
    run_req(1, 2, 0);
    err_req(5);
    err_req(7);
    run_req(3, 0, 1);

    // Reset in the middle of a Count=2 scan while a word is valid.
    bus.Start = 1'b1; bus.Count = 3'd2; bus.Ready = 1'b1;
    step();
    bus.Start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = bus.Valid;
    end
    chk("mid_valid_seen", {31'd0, seen}, 32'd1);
    nReset = 1'b0;
    step();
    chk_zero("midreset");
    nReset = 1'b1;
    run_req(1, 0, 0);

    // Reset wins over an Error-producing Start on the same edge.
    nReset = 1'b0; bus.Start = 1'b1; bus.Count = 3'd6;
    step();
    bus.Start = 1'b0;
    chk_zero("reset_err");
    nReset = 1'b1;
    step();
    chk("reset_err_after", {31'd0, bus.Error}, 32'd0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        err_req($urandom_range(5, 7));
      end else begin
        n = $urandom_range(0, 4);
        run_req(n, 1, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/popcount_decoder_seq.md
POPCOUNT_DECODER_SEQ -- requirements
Module: popcount_decoder_seq

Interface
REQ-001 The module SHALL have no parameters; the word width is fixed at 4 bits and the count width at 3 bits.
REQ-002 Clock  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 nReset  input  1  reset, synchronous and active-low; sampled on the Clock rising edge.
REQ-004 Count  input  3  requested number of ones, 0..4 legal; sampled only when a Start is accepted.
REQ-005 Start  input  1  request pulse; accepted only when Busy=0.
REQ-006 Ready  input  1  downstream accepts Word when Valid=1 and Ready=1 on the same edge.
REQ-007 Busy  output  1  high from the accepted Start until the Last word is accepted.
REQ-008 Word  output  4  candidate pattern, registered; bit mapping {A,B,C,D} = Word[3:0].
REQ-009 Valid  output  1  Word holds a pattern whose population count equals the latched Count.
REQ-010 Last  output  1  qualifies Valid; marks the final pattern of the request.
REQ-011 Error  output  1  one-cycle pulse; Start was accepted with Count greater than 4.

Function
REQ-012 The FSM SHALL have three states: IDLE, SCAN and DRAIN. Busy SHALL be 1 in SCAN and DRAIN.
REQ-013 IDLE, Start=1, Count<=4: the block SHALL latch Count into N, clear the 4-bit candidate counter c to 0 and enter SCAN.
REQ-014 IDLE, Start=1, Count>4: the block SHALL assert Error for exactly the next cycle, stay in IDLE and not assert Valid.
REQ-015 The block SHALL ignore Start while Busy=1; N SHALL NOT change during the request.
REQ-016 Each SCAN edge with no stall (stall = Valid=1 and Ready=0) SHALL evaluate c, then increment c.
REQ-017 If popcount(c)==N on that edge, the block SHALL load Word=c and Valid=1; otherwise it SHALL load Valid=0 and leave Word unchanged.
REQ-018 On a match, the block SHALL set Last=1 iff c equals the highest pattern for N: 0000, 1000, 1100, 1110 or 1111 for N = 0..4. On that edge the FSM SHALL move to DRAIN.
REQ-019 On a stall, Word, Valid, Last, c and the state SHALL all hold.
REQ-020 DRAIN: when Valid=1 and Ready=1, the block SHALL clear Valid and Last, enter IDLE and drop Busy.
REQ-021 Pattern order SHALL be strictly ascending. Counts per request SHALL be 1, 4, 6, 4 and 1 words for N = 0..4, with no duplicates or omissions.
REQ-022 Latency: with Ready held at 1, the first Valid SHALL appear on the edge after the Start edge plus the value of the lowest matching pattern. Examples: N=0 gives 1 edge; N=1 gives Word=0001 at edge 2.
REQ-023 With Ready held at 1, the Last word SHALL be loaded at edge 1+c_last after Start. For N=4 this is edge 16, and c SHALL never wrap within a request.
REQ-024 A new Start SHALL be accepted on the same edge that Busy is sampled low, i.e. the cycle after the last word is accepted.

Reset
REQ-025 With nReset=0 at a Clock edge, the block SHALL set state=IDLE, c=0, N=0, Word=0000, Valid=0, Last=0, Busy=0 and Error=0.
REQ-026 Reset SHALL take priority over every other input, including during SCAN, DRAIN, a stall or a pending Error. No partial request SHALL resume after reset.
REQ-027 The outputs SHALL be undefined only before the first reset edge.

Verification
REQ-028 Count=2, Ready=1 -> Valid words 0011, 0101, 0110, 1001, 1010, 1100; Last only with 1100; Busy falls the edge after 1100 is accepted.
REQ-029 Count=0, then Count=4, Ready=1 -> single word 0000 with Last at edge 1; single word 1111 with Last at edge 16.
REQ-030 Count=1, Ready low for 3 cycles while Word=0100 is valid -> Word and Valid hold for 3 cycles; next word 1000 with Last; no skipped pattern.
REQ-031 Start with Count=5, and separately Count=7 -> Error=1 for one cycle, Busy=0, Valid never asserted.
REQ-032 Start pulsed again with Count=4 during a Count=3 request -> output stays 0111, 1011, 1101, 1110; the second Start is ignored.
REQ-033 nReset=0 mid-SCAN of Count=2 with Valid=1 -> next edge all outputs zero and IDLE; the following Start with Count=1 produces 0001 first.
